isp_frame_reader: RTL

Parametrised crop-and-unpack front end for the ISP pipeline. It walks a raw Bayer frame stored as packed words in memory, fetches only the words covering the crop window, and unpacks them. The output is a valid/ready pixel stream with row and frame markers. It replaces the fixed 16-bit, 64-bit-word read path ahead of black-level and colour stages, and adds backpressure and arbitrary left-margin lane alignment.

---
 rtl/isp_pkg.sv | 38 +++
 rtl/isp_frame_reader_if.sv | 47 ++++
 rtl/isp_word_unpacker.sv | 46 ++++
 rtl/isp_frame_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared types and helpers for the ISP raw frame reader: FSM state encoding,
// lane extraction from a packed memory word and the lanes-per-word log2.
package isp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } reader_state_t;

    // Widest memory word lane_sel accepts; callers zero-extend into this.
    localparam int unsigned LANE_SEL_MAX_W = 256;

    function automatic int unsigned ppw_log2(input int unsigned ppw);
        int unsigned result;
        result = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (ppw == (32'd1 << i)) begin
                result = unsigned'(i);
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Lane 0 sits in the most significant bits; the caller truncates to pixel width.
    function automatic logic [LANE_SEL_MAX_W-1:0] lane_sel(
        input logic [LANE_SEL_MAX_W-1:0] word,
        input int unsigned               lane,
        input int unsigned               pixel_width,
        input int unsigned               word_width
    );
        return word >> (word_width - (lane + 32'd1) * pixel_width);
    endfunction

endpackage

// File: rtl/isp_frame_reader_if.sv
// Memory read port and pixel stream of the ISP frame reader. pix_bayer exists
// only when ISP_FRAME_READER_BAYER_EN is defined.
interface isp_frame_reader_if #(
    parameter int unsigned PIXEL_WIDTH = 16,
    parameter int unsigned WORD_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]  read_address;
    logic [WORD_WIDTH-1:0]  read_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PIXEL_WIDTH-1:0] pix_data;
    logic                   pix_sof;
    logic                   pix_eol;
    logic                   pix_eof;
`ifdef ISP_FRAME_READER_BAYER_EN
    logic [1:0]             pix_bayer;
`endif

    modport master (
        output read_address,
        input  read_data,
        output pix_valid,
        input  pix_ready,
        output pix_data,
        output pix_sof,
        output pix_eol,
        output pix_eof
`ifdef ISP_FRAME_READER_BAYER_EN
        , output pix_bayer
`endif
    );

    modport slave (
        input  read_address,
        output read_data,
        input  pix_valid,
        output pix_ready,
        input  pix_data,
        input  pix_sof,
        input  pix_eol,
        input  pix_eof
`ifdef ISP_FRAME_READER_BAYER_EN
        , input pix_bayer
`endif
    );
endinterface

// File: rtl/isp_word_unpacker.sv
// Holds the current memory word and steps through its pixel lanes; on the
// last lane it swaps in the next word so a row streams without gaps.
module isp_word_unpacker
    import isp_pkg::*;
#(
    parameter  int unsigned PIXEL_WIDTH = 16,
    parameter  int unsigned WORD_WIDTH  = 64,
    localparam int unsigned PPW         = WORD_WIDTH / PIXEL_WIDTH,
    localparam int unsigned LANE_W      = ppw_log2(PPW)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_word,
    input  logic [LANE_W-1:0]      start_lane,
    input  logic                   advance,
    input  logic [WORD_WIDTH-1:0]  read_data,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   last_lane
);

    logic [WORD_WIDTH-1:0] word_r;
    logic [LANE_W-1:0]     lane_r;

    // Word register and lane counter: row start loads at the crop lane, wrap fetches the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= '0;
            lane_r <= '0;
        end else if (load_word) begin
            word_r <= read_data;
            lane_r <= start_lane;
        end else if (advance) begin
            if (last_lane) begin
                word_r <= read_data;
                lane_r <= '0;
            end else begin
                lane_r <= lane_r + LANE_W'(1'b1);
            end
        end
    end

    assign last_lane = (lane_r == LANE_W'(PPW - 32'd1));
    assign pixel     = PIXEL_WIDTH'(lane_sel(LANE_SEL_MAX_W'(word_r), 32'(lane_r),
                                             PIXEL_WIDTH, WORD_WIDTH));

endmodule

// File: rtl/isp_frame_reader.sv
// Crop-and-unpack reader: walks the crop window of a packed raw frame and emits
// a backpressured pixel stream. Optional pix_bayer via ISP_FRAME_READER_BAYER_EN.
module isp_frame_reader
    import isp_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = 16,
    parameter int unsigned WORD_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DIM_WIDTH    = 16,
    parameter int unsigned MARGIN_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_frame,
    input  logic [ADDR_WIDTH-1:0]   base_address,
    input  logic [DIM_WIDTH-1:0]    frame_width,
    input  logic [MARGIN_WIDTH-1:0] top_margin,
    input  logic [MARGIN_WIDTH-1:0] left_margin,
    input  logic [DIM_WIDTH-1:0]    crop_height,
    input  logic [DIM_WIDTH-1:0]    crop_width,
    isp_frame_reader_if.master      bus,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int unsigned PPW    = WORD_WIDTH / PIXEL_WIDTH;
    localparam int unsigned LANE_W = ppw_log2(PPW);

    reader_state_t          state_r, state_s;
    logic [ADDR_WIDTH-1:0]  base_r, read_address_r;
    logic [DIM_WIDTH-1:0]   fw_r, crop_h_r, crop_w_r, row_r, col_r;
    logic [31:0]            row_off_r, start_off_s, next_row_off_s;
    logic                   last_loaded_r;
    logic                   start_s, cfg_zero_s, out_free_s, row_end_s, frame_end_s;
    logic                   eof_accept_s, word_load_s, load_pix_s, last_lane_s;
    logic [PIXEL_WIDTH-1:0] unpacked_s;
    logic                   pix_valid_r, pix_sof_r, pix_eol_r, pix_eof_r;
    logic [PIXEL_WIDTH-1:0] pix_data_r;
    logic                   busy_r, frame_done_r;

    // Only the crop origin row uses a product; later rows just add the pitch.
    assign start_off_s    = 32'(top_margin) * 32'(frame_width) + 32'(left_margin);
    assign next_row_off_s = row_off_r + 32'(fw_r);
    assign start_s        = (state_r == IDLE) && new_frame;
    assign cfg_zero_s     = (crop_height == '0) || (crop_width == '0);
    assign out_free_s     = !pix_valid_r || bus.pix_ready;
    assign row_end_s      = (col_r == crop_w_r - DIM_WIDTH'(1'b1));
    assign frame_end_s    = row_end_s && (row_r == crop_h_r - DIM_WIDTH'(1'b1));
    assign eof_accept_s   = pix_valid_r && bus.pix_ready && pix_eof_r;

    isp_word_unpacker #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH)
    ) u_unpacker (
        .clk        (clk),
        .reset      (reset),
        .load_word  (word_load_s),
        .start_lane (row_off_r[LANE_W-1:0]),
        .advance    (load_pix_s),
        .read_data  (bus.read_data),
        .pixel      (unpacked_s),
        .last_lane  (last_lane_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and per-cycle strobes.
    always_comb begin
        state_s     = state_r;
        word_load_s = 1'b0;
        load_pix_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (new_frame) begin
                    if (cfg_zero_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                word_load_s = 1'b1;
                state_s     = STREAM;
            end
            STREAM: begin
                load_pix_s = out_free_s && !last_loaded_r;
                if (eof_accept_s) begin
                    state_s = DONE;
                end else if (load_pix_s && row_end_s && !frame_end_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = STREAM;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Frame configuration captured at the start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r   <= '0;
            fw_r     <= '0;
            crop_h_r <= '0;
            crop_w_r <= '0;
        end else if (start_s) begin
            base_r   <= base_address;
            fw_r     <= frame_width;
            crop_h_r <= crop_height;
            crop_w_r <= crop_width;
        end
    end

    // Row/column walk and word address generation; read_address always leads the word register by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r          <= '0;
            col_r          <= '0;
            row_off_r      <= 32'd0;
            read_address_r <= '0;
            last_loaded_r  <= 1'b0;
        end else if (start_s) begin
            row_r          <= '0;
            col_r          <= '0;
            row_off_r      <= start_off_s;
            read_address_r <= base_address + ADDR_WIDTH'(start_off_s >> LANE_W);
            last_loaded_r  <= 1'b0;
        end else if (word_load_s) begin
            read_address_r <= read_address_r + ADDR_WIDTH'(1'b1);
        end else if (load_pix_s) begin
            if (frame_end_s) begin
                last_loaded_r <= 1'b1;
            end else if (row_end_s) begin
                col_r          <= '0;
                row_r          <= row_r + DIM_WIDTH'(1'b1);
                row_off_r      <= next_row_off_s;
                read_address_r <= base_r + ADDR_WIDTH'(next_row_off_s >> LANE_W);
            end else begin
                col_r <= col_r + DIM_WIDTH'(1'b1);
                if (last_lane_s) begin
                    read_address_r <= read_address_r + ADDR_WIDTH'(1'b1);
                end
            end
        end
    end

    // Output register: loads when empty or accepted, otherwise holds under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid_r <= 1'b0;
            pix_data_r  <= '0;
            pix_sof_r   <= 1'b0;
            pix_eol_r   <= 1'b0;
            pix_eof_r   <= 1'b0;
        end else if (load_pix_s) begin
            pix_valid_r <= 1'b1;
            pix_data_r  <= unpacked_s;
            pix_sof_r   <= (row_r == '0) && (col_r == '0);
            pix_eol_r   <= row_end_s;
            pix_eof_r   <= frame_end_s;
        end else if (bus.pix_ready) begin
            pix_valid_r <= 1'b0;
        end
    end

`ifdef ISP_FRAME_READER_BAYER_EN
    logic       top_par_r, left_par_r;
    logic [1:0] pix_bayer_r;

    // Bayer phase origin captured with the rest of the configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_par_r  <= 1'b0;
            left_par_r <= 1'b0;
        end else if (start_s) begin
            top_par_r  <= top_margin[0];
            left_par_r <= left_margin[0];
        end
    end

    // Bayer phase travels with pix_data through the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_bayer_r <= 2'b00;
        end else if (load_pix_s) begin
            pix_bayer_r <= {top_par_r ^ row_r[0], left_par_r ^ col_r[0]};
        end
    end

    assign bus.pix_bayer = pix_bayer_r;
`endif

    // Frame status: busy spans LOAD through DONE, frame_done marks the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (state_s == DONE) && (state_r != DONE);
            if (start_s) begin
                busy_r <= 1'b1;
            end else if (state_r == DONE) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign bus.read_address = read_address_r;
    assign bus.pix_valid    = pix_valid_r;
    assign bus.pix_data     = pix_data_r;
    assign bus.pix_sof      = pix_sof_r;
    assign bus.pix_eol      = pix_eol_r;
    assign bus.pix_eof      = pix_eof_r;
    assign busy             = busy_r;
    assign frame_done       = frame_done_r;

endmodule
